// File: rtl/rr_adder_sequencer_pkg.sv
// Shared definitions for the round-robin nibble-serial adder sequencer.
package adder_seq_pkg;

    // Default number of 4-bit passes per operation.
    localparam int NIBBLES_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a counter that must hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_adder_sequencer_if.sv
// Request/response bundle between the two requesters, the consumer and the sequencer.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are both
// high. A request holds its operands while waiting; the sequencer holds rsp_* stable
// while rsp_valid is high and rsp_ready is low.
interface rr_adder_sequencer_if #(
    parameter int NIBBLES = adder_seq_pkg::NIBBLES_DEFAULT
);
    localparam int W = 4 * NIBBLES;

    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [2*W-1:0] req_a;
    logic [2*W-1:0] req_b;
    logic [1:0]     req_cin;
    logic           rsp_valid;
    logic           rsp_ready;
    logic           rsp_id;
    logic [W-1:0]   rsp_sum;
    logic           rsp_cout;
    logic           busy;

    // Sequencer side.
    modport slave (
        input  req_valid, req_a, req_b, req_cin, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
    );

    // Requester/consumer side.
    modport master (
        output req_valid, req_a, req_b, req_cin, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
    );

endinterface

// File: rtl/rr_adder_sequencer_adder.sv
// Combinational 4-bit ripple-carry adder; the single shared datapath element.
module ripple_carry_adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] c;

    assign c[0] = cin;

    // One full adder per bit, carry rippling upward.
    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[4];

endmodule

// File: rtl/rr_adder_sequencer.sv
// Two-requester round-robin front end feeding a nibble-serial adder: one nibble
// per RUN cycle through a shared 4-bit ripple adder, result held in DONE until taken.
module rr_adder_sequencer
    import adder_seq_pkg::*;
#(
    parameter int NIBBLES = NIBBLES_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rr_adder_sequencer_if.slave  bus,
    output state_t               state_dbg
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = cnt_width(NIBBLES);

    state_t          state;
    logic            rr_ptr;      // requester favoured when both are valid
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    sum_q;
    logic            id_q;
    logic            carry_q;
    logic            cout_q;
    logic            rsp_valid_q;
    logic [CW-1:0]   cnt_q;

    logic            grant_id;
    logic            accept;
    logic [3:0]      a_nib;
    logic [3:0]      b_nib;
    logic [3:0]      add_sum;
    logic            add_cout;

    // Grant: the lone valid requester, or the pointer's choice when both ask.
    always_comb begin
        grant_id = 1'b0;
        if (bus.req_valid == 2'b11) grant_id = rr_ptr;
        else                        grant_id = bus.req_valid[1];
    end

    assign accept        = (state == IDLE) && (|bus.req_valid);
    assign bus.req_ready = accept ? (grant_id ? 2'b10 : 2'b01) : 2'b00;

    // Select nibble k of the captured operands for the shared adder.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int k = 0; k < NIBBLES; k++) begin
            if (cnt_q == CW'(k)) begin
                a_nib = a_q[4*k +: 4];
                b_nib = b_q[4*k +: 4];
            end
        end
    end

    ripple_carry_adder_4bit u_adder (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Sequencer FSM: capture on acceptance, one nibble per RUN cycle, hold in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            id_q        <= 1'b0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q     <= grant_id ? bus.req_a[2*W-1:W] : bus.req_a[W-1:0];
                        b_q     <= grant_id ? bus.req_b[2*W-1:W] : bus.req_b[W-1:0];
                        carry_q <= bus.req_cin[grant_id];
                        id_q    <= grant_id;
                        rr_ptr  <= ~grant_id;
                        cnt_q   <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    for (int k = 0; k < NIBBLES; k++) begin
                        if (cnt_q == CW'(k)) sum_q[4*k +: 4] <= add_sum;
                    end
                    carry_q <= add_cout;
                    if (cnt_q == CW'(NIBBLES - 1)) begin
                        cout_q      <= add_cout;
                        rsp_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_cout  = cout_q;
    assign bus.busy      = (state != IDLE);
    assign state_dbg     = state;

endmodule

// File: tb/tb_rr_adder_sequencer.sv
// Self-checking bench for rr_adder_sequencer: directed corner cases plus random
// traffic, checked against an arithmetic/arbitration reference model.
module tb_rr_adder_sequencer;
    import adder_seq_pkg::*;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic   clk;
    logic   rst_n;
    state_t state_dbg;

    rr_adder_sequencer_if #(.NIBBLES(NIB)) bus ();

    rr_adder_sequencer #(.NIBBLES(NIB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state: id served most recently (1 => requester 0 favoured).
    int last_id = 1;

    // Scoreboard entries: {id, cout, sum}.
    logic [W+1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check_eq({tag, ".rsp_id"},    32'(bus.rsp_id),    32'd0);
        check_eq({tag, ".rsp_sum"},   32'(bus.rsp_sum),   32'd0);
        check_eq({tag, ".rsp_cout"},  32'(bus.rsp_cout),  32'd0);
        check_eq({tag, ".busy"},      32'(bus.busy),      32'd0);
        check_eq({tag, ".req_ready"}, 32'(bus.req_ready), 32'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b0;
        #1;
        check_idle_outputs("reset");
        check_eq("reset.state", 32'(state_dbg), 32'(IDLE));
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        last_id = 1;
    endtask

    // Model of the arbiter: a lone requester wins, otherwise the one not served last.
    function automatic int model_grant(input logic [1:0] v);
        if (v == 2'b11) return (last_id == 0) ? 1 : 0;
        return v[1] ? 1 : 0;
    endfunction

    // ---------------- driver ----------------
    // Presents a request, checks the grant, waits for the result, optionally holds
    // rsp_ready low for `hold` cycles, then takes the result and checks it.
    task automatic do_op(input logic [2*W-1:0] a, input logic [2*W-1:0] b,
                         input logic [1:0] cin, input logic [1:0] vmask, input int hold);
        int              gid;
        int              lat;
        logic [W:0]      full;
        logic [W+1:0]    e;
        @(negedge clk);
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_cin   = cin;
        bus.req_valid = vmask;
        bus.rsp_ready = 1'b0;
        gid = model_grant(vmask);
        #1;
        check_eq("grant", 32'(bus.req_ready), (gid == 1) ? 32'd2 : 32'd1);
        full = (W+1)'(a[gid*W +: W]) + (W+1)'(b[gid*W +: W]) + (W+1)'(cin[gid]);
        exp_q.push_back({gid[0], full});
        last_id = gid;
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        check_eq("run.busy", 32'(bus.busy), 32'd1);
        lat = 0;
        while (!bus.rsp_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("latency", 32'(lat), 32'(NIB));
        e = exp_q[0];
        // Backpressure: results stable, nothing accepted even with both valid.
        for (int i = 0; i < hold; i++) begin
            bus.req_valid = 2'b11;
            #1;
            check_eq("hold.req_ready", 32'(bus.req_ready), 32'd0);
            check_eq("hold.busy",      32'(bus.busy),      32'd1);
            check_eq("hold.sum",       32'(bus.rsp_sum),   32'(e[W-1:0]));
            check_eq("hold.valid",     32'(bus.rsp_valid), 32'd1);
            @(posedge clk);
            #1;
        end
        bus.req_valid = 2'b00;
        e = exp_q.pop_front();
        check_eq("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check_eq("rsp_sum",   32'(bus.rsp_sum),   32'(e[W-1:0]));
        check_eq("rsp_cout",  32'(bus.rsp_cout),  32'(e[W]));
        check_eq("rsp_id",    32'(bus.rsp_id),    32'(e[W+1]));
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        check_eq("post.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("post.busy",      32'(bus.busy),      32'd0);
    endtask

    // Starts an operation on requester 0 and resets it at RUN nibble 2.
    task automatic reset_mid_run();
        int seen;
        @(negedge clk);
        bus.req_a     = {16'h0, 16'hABCD};
        bus.req_b     = {16'h0, 16'h1111};
        bus.req_cin   = 2'b00;
        bus.req_valid = 2'b01;
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        @(negedge clk);
        rst_n   = 1'b1;
        last_id = 1;
        seen = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid) seen++;
        end
        check_eq("midrst.no_rsp", 32'(seen), 32'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [2*W-1:0] ra;
        logic [2*W-1:0] rb;
        logic [1:0]     rc;
        logic [1:0]     rv;

        rst_n         = 1'b0;
        bus.req_valid = 2'b00;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_cin   = 2'b00;
        bus.rsp_ready = 1'b0;
        apply_reset();

        // Single add on requester 0.
        do_op({16'h0, 16'h1234}, {16'h0, 16'h4321}, 2'b00, 2'b01, 0);
        // Full carry ripple, and carry-in alone, on both requesters.
        do_op({16'h0, 16'hFFFF}, {16'h0, 16'h0001}, 2'b00, 2'b01, 0);
        do_op({16'h0000, 16'h0}, {16'h0000, 16'h0}, 2'b10, 2'b10, 0);
        do_op({16'hFFFF, 16'h0}, {16'hFFFF, 16'h0}, 2'b10, 2'b10, 0);

        // Arbitration alternation from reset, with backpressure on the middle one.
        apply_reset();
        do_op({16'h1111, 16'h2222}, {16'h0303, 16'h0404}, 2'b01, 2'b11, 0);
        do_op({16'h5555, 16'h6666}, {16'h0707, 16'h0808}, 2'b10, 2'b11, 5);
        do_op({16'h9999, 16'hAAAA}, {16'h0B0B, 16'h0C0C}, 2'b11, 2'b11, 0);

        // Reset while an operation is in flight; requester 0 wins afterwards.
        reset_mid_run();
        do_op({16'h4444, 16'h8888}, {16'h1000, 16'h7FFF}, 2'b01, 2'b11, 0);

        // Random traffic.
        for (int n = 0; n < 25; n++) begin
            ra = {16'($urandom), 16'($urandom)};
            rb = {16'($urandom), 16'($urandom)};
            rc = 2'($urandom_range(0, 3));
            rv = 2'($urandom_range(1, 3));
            do_op(ra, rb, rc, rv, $urandom_range(0, 3));
        end

        check_eq("scoreboard.empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
